// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle main controller.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [1:0] ALUCTL_ADD = 2'b00;
    localparam logic [1:0] ALUCTL_SUB = 2'b01;
    localparam logic [1:0] ALUCTL_AND = 2'b10;
    localparam logic [1:0] ALUCTL_ORR = 2'b11;

    // Only the arithmetic ops produce meaningful carry/overflow flags.
    function automatic logic is_arith(input logic [1:0] code);
        return (code == ALUCTL_ADD) || (code == ALUCTL_SUB);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_alu_decoder.sv
// Combinational ALU decoder: maps the data-processing cmd/S bits to ALU
// operation, flag-write requests and a no-writeback indication.
module alu_decoder
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTL_W = 2
) (
    input  logic [5:0]          funct,
    input  logic                active,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic [1:0]          flag_w,
    output logic                no_write
);

    logic [1:0] code;
    logic       is_cmp;

    // Decode cmd; no_write stays valid outside the execute states so the
    // writeback state can still use it.
    always_comb begin
        code        = ALUCTL_ADD;
        no_write    = 1'b0;
        is_cmp      = 1'b0;
        alu_control = ALUCTL_W'(ALUCTL_ADD);
        flag_w      = 2'b00;
        case (funct[4:1])
            CMD_ADD: code = ALUCTL_ADD;
            CMD_SUB: code = ALUCTL_SUB;
            CMD_AND: code = ALUCTL_AND;
            CMD_ORR: code = ALUCTL_ORR;
            CMD_CMP: begin
                code     = ALUCTL_SUB;
                no_write = 1'b1;
                is_cmp   = 1'b1;
            end
            default: begin
                code     = ALUCTL_ADD;
                no_write = 1'b1;
            end
        endcase
        if (active) begin
            alu_control = ALUCTL_W'(code);
            if (is_cmp) begin
                flag_w = 2'b11;
            end else begin
                flag_w = {funct[0], funct[0] & is_arith(code)};
            end
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle main controller. Sequences datapath muxes/enables per
// instruction phase and issues write requests (PCS/RegW/MemW/FlagW) that
// downstream condition logic gates. Stalls on mem_ready in FETCH/MEMRD/MEMWR.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTL_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          Op,
    input  logic [5:0]          Funct,
    input  logic [3:0]          Rd,
    input  logic                mem_ready,
    output logic                IRWrite,
    output logic                NextPC,
    output logic                AdrSrc,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ResultSrc,
    output logic [1:0]          ImmSrc,
    output logic [1:0]          RegSrc,
    output logic [ALUCTL_W-1:0] ALUControl,
    output logic                PCS,
    output logic                RegW,
    output logic                MemW,
    output logic [1:0]          FlagW
);

    state_t                state;
    state_t                next_state;
    logic                  fetch_q;
    logic                  memw_q;
    logic                  adrsrc_q;
    logic                  alusrca_q;
    logic [1:0]            alusrcb_q;
    logic [1:0]            resultsrc_q;
    logic [ALUCTL_W-1:0]   aluctl_q;
    logic                  pcs_q;
    logic                  regw_q;
    logic [1:0]            flagw_q;
    logic                  dec_active;
    logic [ALUCTL_W-1:0]   dec_alu;
    logic [1:0]            dec_flagw;
    logic                  dec_nowrite;
    logic                  rd_is_pc;

    assign rd_is_pc   = (Rd == 4'd15);
    assign dec_active = (next_state == S_EXECR) || (next_state == S_EXECI);

    alu_decoder #(
        .ALUCTL_W (ALUCTL_W)
    ) u_alu_decoder (
        .funct       (Funct),
        .active      (dec_active),
        .alu_control (dec_alu),
        .flag_w      (dec_flagw),
        .no_write    (dec_nowrite)
    );

    // Next-state selection, including the mem_ready stalls.
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_MEM:  next_state = S_MEMADR;
                    OP_DP:   next_state = Funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:   next_state = S_BRANCH;
                    default: next_state = S_FETCH;
                endcase
            end
            S_MEMADR: next_state = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
            S_MEMWB:  next_state = S_FETCH;
            S_EXECR:  next_state = S_ALUWB;
            S_EXECI:  next_state = S_ALUWB;
            S_ALUWB:  next_state = S_FETCH;
            S_BRANCH: next_state = S_FETCH;
            default:  next_state = S_FETCH;
        endcase
    end

    // State register with outputs registered from the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_FETCH;
            fetch_q     <= 1'b1;
            memw_q      <= 1'b0;
            adrsrc_q    <= 1'b0;
            alusrca_q   <= 1'b1;
            alusrcb_q   <= 2'b10;
            resultsrc_q <= 2'b10;
            aluctl_q    <= ALUCTL_W'(ALUCTL_ADD);
            pcs_q       <= 1'b0;
            regw_q      <= 1'b0;
            flagw_q     <= 2'b00;
        end else begin
            state       <= next_state;
            fetch_q     <= 1'b0;
            memw_q      <= 1'b0;
            adrsrc_q    <= 1'b0;
            alusrca_q   <= 1'b0;
            alusrcb_q   <= 2'b00;
            resultsrc_q <= 2'b00;
            aluctl_q    <= ALUCTL_W'(ALUCTL_ADD);
            pcs_q       <= 1'b0;
            regw_q      <= 1'b0;
            flagw_q     <= 2'b00;
            case (next_state)
                S_FETCH: begin
                    fetch_q     <= 1'b1;
                    alusrca_q   <= 1'b1;
                    alusrcb_q   <= 2'b10;
                    resultsrc_q <= 2'b10;
                end
                S_DECODE: begin
                    alusrca_q   <= 1'b1;
                    alusrcb_q   <= 2'b10;
                    resultsrc_q <= 2'b10;
                end
                S_MEMADR: begin
                    alusrcb_q <= 2'b01;
                end
                S_MEMRD: begin
                    adrsrc_q <= 1'b1;
                end
                S_MEMWR: begin
                    adrsrc_q <= 1'b1;
                    memw_q   <= 1'b1;
                end
                S_MEMWB: begin
                    resultsrc_q <= 2'b01;
                    regw_q      <= 1'b1;
                    pcs_q       <= rd_is_pc;
                end
                S_EXECR: begin
                    aluctl_q <= dec_alu;
                    flagw_q  <= dec_flagw;
                end
                S_EXECI: begin
                    alusrcb_q <= 2'b01;
                    aluctl_q  <= dec_alu;
                    flagw_q   <= dec_flagw;
                end
                S_ALUWB: begin
                    regw_q <= !dec_nowrite;
                    pcs_q  <= rd_is_pc & !dec_nowrite;
                end
                S_BRANCH: begin
                    alusrcb_q   <= 2'b01;
                    resultsrc_q <= 2'b10;
                    pcs_q       <= 1'b1;
                end
                default: begin
                    fetch_q <= 1'b0;
                end
            endcase
        end
    end

    // Handshake strobes fire only on the completing cycle; fetch strobes
    // are also held off while reset is asserted.
    assign IRWrite    = fetch_q & mem_ready & reset;
    assign NextPC     = fetch_q & mem_ready & reset;
    assign MemW       = memw_q & mem_ready;
    assign AdrSrc     = adrsrc_q;
    assign ALUSrcA    = alusrca_q;
    assign ALUSrcB    = alusrcb_q;
    assign ResultSrc  = resultsrc_q;
    assign ALUControl = aluctl_q;
    assign PCS        = pcs_q;
    assign RegW       = regw_q;
    assign FlagW      = flagw_q;
    assign ImmSrc     = Op;
    assign RegSrc     = {Op == OP_MEM, Op == OP_BR};

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed scoreboard bench for the multicycle main controller.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       mem_ready;
    logic       IRWrite, NextPC, AdrSrc, ALUSrcA, PCS, RegW, MemW;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, FlagW;

    mc_ctrl_fsm #(.ALUCTL_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .mem_ready  (mem_ready),
        .IRWrite    (IRWrite),
        .NextPC     (NextPC),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .FlagW      (FlagW)
    );

    always #5 clk = ~clk;

    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4;
    localparam int MEMWR = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9;
    localparam logic [1:0] A_ADD = 2'b00, A_SUB = 2'b01, A_AND = 2'b10, A_ORR = 2'b11;

    int checks = 0;
    int failures = 0;
    logic [18:0] expQ[$];
    string       tagQ[$];

    // {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc} expected in each state
    function automatic logic [5:0] muxFor(input int st);
        case (st)
            FETCH:   return 6'b0_1_10_10;
            DECODE:  return 6'b0_1_10_10;
            MEMADR:  return 6'b0_0_01_00;
            MEMRD:   return 6'b1_0_00_00;
            MEMWR:   return 6'b1_0_00_00;
            MEMWB:   return 6'b0_0_00_01;
            EXECR:   return 6'b0_0_00_00;
            EXECI:   return 6'b0_0_01_00;
            ALUWB:   return 6'b0_0_00_00;
            BRANCH:  return 6'b0_0_01_10;
            default: return 6'b0_0_00_00;
        endcase
    endfunction

    task automatic setInstr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
        Op    = op;
        Funct = funct;
        Rd    = rd;
    endtask

    task automatic applyStimulus(input string tag, input int st, input logic mr,
                                 input logic [1:0] alu, input logic [1:0] fw, input logic irn,
                                 input logic regw, input logic pcs, input logic memw);
        logic [5:0]  m;
        logic [18:0] e;
        mem_ready = mr;
        m = muxFor(st);
        e = {irn, irn, m, Op, (Op == 2'b01), (Op == 2'b10), alu, pcs, regw, memw, fw};
        expQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    task automatic checkNow();
        logic [18:0] obs;
        logic [18:0] e;
        string       t;
        obs = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
               ALUControl, PCS, RegW, MemW, FlagW};
        e = expQ.pop_front();
        t = tagQ.pop_front();
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", t, obs, e);
        end
    endtask

    task automatic checkOutput();
        @(negedge clk);
        checkNow();
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input int st, input logic mr,
                        input logic [1:0] alu, input logic [1:0] fw, input logic irn,
                        input logic regw, input logic pcs, input logic memw);
        applyStimulus(tag, st, mr, alu, fw, irn, regw, pcs, memw);
        checkOutput();
        nextEdge();
    endtask

    initial begin
        reset = 1'b1;
        mem_ready = 1'b0;
        setInstr(2'b00, 6'b000000, 4'd0);
        #1 reset = 1'b0;
        step("rst_low", FETCH, 1'b1, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // ADDS R1,R2,#5
        setInstr(2'b00, 6'b101001, 4'd1);
        step("adds_fetch",  FETCH,  1'b1, A_ADD, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step("adds_decode", DECODE, 1'b1, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("adds_execi",  EXECI,  1'b1, A_ADD, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        step("adds_aluwb",  ALUWB,  1'b1, A_ADD, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);

        // CMP register form, with one cycle of fetch stall
        setInstr(2'b00, 6'b010101, 4'd0);
        step("cmp_fetch_hold", FETCH,  1'b0, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("cmp_fetch",      FETCH,  1'b1, A_ADD, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step("cmp_decode",     DECODE, 1'b1, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("cmp_execr",      EXECR,  1'b1, A_SUB, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        step("cmp_aluwb",      ALUWB,  1'b1, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // ORR PC,... without S: writes PC, no flags
        setInstr(2'b00, 6'b011000, 4'd15);
        step("orr_fetch",  FETCH,  1'b1, A_ADD, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step("orr_decode", DECODE, 1'b1, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("orr_execr",  EXECR,  1'b1, A_ORR, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("orr_aluwb",  ALUWB,  1'b1, A_ADD, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);

        // ANDS immediate: NZ only
        setInstr(2'b00, 6'b100001, 4'd2);
        step("ands_fetch",  FETCH,  1'b1, A_ADD, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ands_decode", DECODE, 1'b1, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ands_execi",  EXECI,  1'b1, A_AND, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ands_aluwb",  ALUWB,  1'b1, A_ADD, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);

        // LDR PC with 3 cycles of memory stall
        setInstr(2'b01, 6'b011001, 4'd15);
        step("ldr_fetch",  FETCH,  1'b1, A_ADD, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ldr_decode", DECODE, 1'b1, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ldr_memadr", MEMADR, 1'b1, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("ldr_memrd_hold", MEMRD, 1'b0, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        step("ldr_memrd_done", MEMRD, 1'b1, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ldr_memwb",      MEMWB, 1'b0, A_ADD, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);

        // Second LDR aborted by reset while in MEMRD
        setInstr(2'b01, 6'b011001, 4'd4);
        step("ldr2_fetch",  FETCH,  1'b1, A_ADD, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ldr2_decode", DECODE, 1'b1, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ldr2_memadr", MEMADR, 1'b1, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("ldr2_memrd", MEMRD, 1'b0, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput();
        #1 reset = 1'b0;
        applyStimulus("rst_mid", FETCH, 1'b1, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 checkNow();
        nextEdge();
        step("rst_hold", FETCH, 1'b1, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // STR with 2 cycles of memory stall
        setInstr(2'b01, 6'b011000, 4'd3);
        step("str_fetch",   FETCH,  1'b1, A_ADD, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step("str_decode",  DECODE, 1'b1, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("str_memadr",  MEMADR, 1'b1, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("str_hold0",   MEMWR,  1'b0, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("str_hold1",   MEMWR,  1'b0, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("str_write",   MEMWR,  1'b1, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        step("str_refetch", FETCH,  1'b0, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Branch
        setInstr(2'b10, 6'b100000, 4'd0);
        step("b_fetch",   FETCH,  1'b1, A_ADD, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step("b_decode",  DECODE, 1'b1, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("b_branch",  BRANCH, 1'b1, A_ADD, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        step("b_refetch", FETCH,  1'b0, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Illegal opcode: straight back to fetch, no writes
        setInstr(2'b11, 6'b010101, 4'd15);
        step("ill_fetch",   FETCH,  1'b1, A_ADD, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ill_decode",  DECODE, 1'b1, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ill_refetch", FETCH,  1'b0, A_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
